// File: rtl/dsc_mul_sched_if.sv
// dsc_mul_sched_if: requester, response and core-side signals of the DSC multiplier scheduler.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface dsc_mul_sched_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned CYC_W = 25
);
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ZW  = 3 * W;

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*W-1:0] req_c;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [ZW-1:0]  rsp_z;
  logic [CYC_W-1:0] rsp_cycles;
  logic           rsp_err;
  logic           rsp_mismatch;
  logic           core_rst;
  logic           core_en;
  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic [W-1:0]   core_c;
  logic [ZW-1:0]  core_z;
  logic           core_ov;

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready, core_z, core_ov,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_cycles, rsp_err, rsp_mismatch,
           core_rst, core_en, core_a, core_b, core_c
  );

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready, core_z, core_ov,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_cycles, rsp_err, rsp_mismatch,
           core_rst, core_en, core_a, core_b, core_c
  );
endinterface

// File: rtl/dsc_mul_sched.sv
// dsc_mul_sched: round-robin scheduler sharing one 3-input DSC multiplier core among N requesters.
// Optional macro DSC_SCHED_CHECK_EN: compare every captured result against an exact product.
module dsc_mul_sched #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned CYC_W   = 25,
  parameter int unsigned TIMEOUT = 16777300
) (
  input  logic clk,
  input  logic rst,
  dsc_mul_sched_if.slave bus
);
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ZW  = 3 * W;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d, id_q, id_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
  logic [ZW-1:0]    z_q, z_d;
  logic             err_q, err_d, mis_q, mis_d, valid_q, valid_d;
  logic             core_rst_q, core_rst_d, core_en_q, core_en_d;

  logic [N-1:0]     gnt_c;
  logic [IDW-1:0]   gnt_id_c;
  logic             found_c;
  int unsigned      idx_c;
  logic [W-1:0]     sel_a_c, sel_b_c, sel_c_c;
  logic [CYC_W:0]   cnt_p1_c;
  logic [CYC_W-1:0] cnt_sat_c;

`ifdef DSC_SCHED_CHECK_EN
  logic [ZW-1:0]    prod_q;
`endif

  // Cyclic search for the first valid requester after the rr pointer
  always_comb begin
    found_c  = 1'b0;
    gnt_id_c = rr_q;
    gnt_c    = '0;
    idx_c    = 0;
    sel_a_c  = '0;
    sel_b_c  = '0;
    sel_c_c  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx_c = (32'(rr_q) + k) % N;
      if (!found_c && bus.req_valid[IDW'(idx_c)]) begin
        found_c  = 1'b1;
        gnt_id_c = IDW'(idx_c);
      end
    end
    gnt_c[gnt_id_c] = found_c;
    for (int unsigned i = 0; i < N; i++) begin
      if (IDW'(i) == gnt_id_c) begin
        sel_a_c = bus.req_a[i*W +: W];
        sel_b_c = bus.req_b[i*W +: W];
        sel_c_c = bus.req_c[i*W +: W];
      end
    end
  end

  assign cnt_p1_c  = {1'b0, cnt_q} + (CYC_W+1)'(1);
  assign cnt_sat_c = (&cnt_q) ? cnt_q : CYC_W'(cnt_p1_c);

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    cyc_d         = cyc_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    z_d           = z_q;
    err_d         = err_q;
    mis_d         = mis_q;
    valid_d       = valid_q;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          bus.req_ready = rst ? '0 : gnt_c;
          id_d          = gnt_id_c;
          a_d           = sel_a_c;
          b_d           = sel_b_c;
          c_d           = sel_c_c;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_sat_c;
        if (bus.core_ov) begin
          z_d     = bus.core_z;
          cyc_d   = cnt_sat_c;
          err_d   = 1'b0;
`ifdef DSC_SCHED_CHECK_EN
          mis_d   = (bus.core_z != prod_q);
`else
          mis_d   = 1'b0;
`endif
          valid_d = 1'b1;
          state_d = RESP;
        end else if (cnt_p1_c == (CYC_W+1)'(TIMEOUT)) begin
          z_d     = '0;
          cyc_d   = CYC_W'(TIMEOUT);
          err_d   = 1'b1;
`ifdef DSC_SCHED_CHECK_EN
          mis_d   = 1'b1;
`else
          mis_d   = 1'b0;
`endif
          valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          valid_d = 1'b0;
          rr_d    = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Core controls follow the state being entered so they line up with it
    core_en_d  = (state_d == RUN);
    core_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= IDW'(N - 1);
      id_q       <= '0;
      cnt_q      <= '0;
      cyc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      z_q        <= '0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
      valid_q    <= 1'b0;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      z_q        <= z_d;
      err_q      <= err_d;
      mis_q      <= mis_d;
      valid_q    <= valid_d;
      core_rst_q <= core_rst_d;
      core_en_q  <= core_en_d;
    end
  end

`ifdef DSC_SCHED_CHECK_EN
  // Reference product, settled while the core is held in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
    end else if (state_q == LOAD) begin
      prod_q <= ZW'(a_q) * ZW'(b_q) * ZW'(c_q);
    end
  end
`endif

  assign bus.rsp_valid    = valid_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_z        = z_q;
  assign bus.rsp_cycles   = cyc_q;
  assign bus.rsp_err      = err_q;
  assign bus.rsp_mismatch = mis_q;
  assign bus.core_rst     = core_rst_q;
  assign bus.core_en      = core_en_q;
  assign bus.core_a       = a_q;
  assign bus.core_b       = b_q;
  assign bus.core_c       = c_q;
endmodule

// File: tb/tb_dsc_mul_sched.sv
// tb_dsc_mul_sched: directed and randomized job-level checks of dsc_mul_sched against
// a behavioural core model and a round-robin/latency reference model.
module tb_dsc_mul_sched;
  localparam int unsigned N     = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned CYC_W = 25;
  localparam int unsigned TO    = 50;
`ifdef DSC_SCHED_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsc_mul_sched_if #(.N(N), .W(W), .CYC_W(CYC_W)) bus ();
  dsc_mul_sched #(.N(N), .W(W), .CYC_W(CYC_W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core model: ov on the ov_lat-th enabled cycle after reset release, z = a*b*c (+1 when faulty)
  int ov_lat = 1;
  int ov_cnt = 0;
  bit fault  = 1'b0;
  always_ff @(posedge clk) begin
    if (bus.core_rst) ov_cnt <= 0;
    else if (bus.core_en) ov_cnt <= ov_cnt + 1;
  end
  assign bus.core_ov = bus.core_en && !bus.core_rst && (ov_cnt == ov_lat - 1);
  assign bus.core_z  = 24'(bus.core_a) * 24'(bus.core_b) * 24'(bus.core_c) + 24'(fault);

  int checks   = 0;
  int failures = 0;
  int last_id  = N - 1;
  logic [W-1:0] la [N];
  logic [W-1:0] lb [N];
  logic [W-1:0] lc [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      la[i] = W'($urandom);
      lb[i] = W'($urandom);
      lc[i] = W'($urandom);
    end
  endtask

  // Called in an IDLE cycle just after the falling edge; returns at LOAD, just after the falling edge
  task automatic issue(input logic [N-1:0] pat, input logic [N-1:0] pend, input int lat,
                       input bit flt, output int id);
    logic [N-1:0] g;
    int i;
    id = -1;
    for (int k = 1; k <= N; k++) begin
      i = (last_id + k) % N;
      if (pat[i] && id < 0) id = i;
    end
    g = '0;
    g[id] = 1'b1;
    for (int j = 0; j < N; j++) begin
      bus.req_a[j*W +: W] = la[j];
      bus.req_b[j*W +: W] = lb[j];
      bus.req_c[j*W +: W] = lc[j];
    end
    ov_lat = lat;
    fault  = flt;
    bus.req_valid = pat;
    #1;
    check_eq("grant", 64'(bus.req_ready), 64'(g));
    @(negedge clk);
    bus.req_valid = pend;
    #1;
    check_eq("load_ready", 64'(bus.req_ready), 64'(0));
    check_eq("load_core_rst", 64'(bus.core_rst), 64'(1));
    check_eq("load_core_en", 64'(bus.core_en), 64'(0));
    check_eq("load_a", 64'(bus.core_a), 64'(la[id]));
    check_eq("load_b", 64'(bus.core_b), 64'(lb[id]));
    check_eq("load_c", 64'(bus.core_c), 64'(lc[id]));
  endtask

  // Follows the job through RUN and RESP; returns in the following IDLE cycle
  task automatic complete(input int id, input int lat, input int stall, input bit flt);
    int  run_len;
    bit  err;
    logic [23:0] ez;
    bit  em;
    run_len = (lat <= int'(TO)) ? lat : int'(TO);
    err     = (lat > int'(TO));
    ez      = err ? 24'd0 : 24'(la[id]) * 24'(lb[id]) * 24'(lc[id]) + 24'(flt);
    em      = CHK && (err || flt);
    for (int k = 2; k <= run_len + 2; k++) begin
      @(negedge clk);
      #1;
      if (k == 2) begin
        check_eq("run_core_en", 64'(bus.core_en), 64'(1));
        check_eq("run_core_rst", 64'(bus.core_rst), 64'(0));
      end
      if (k < run_len + 2) begin
        check_eq("valid_early", 64'(bus.rsp_valid), 64'(0));
        check_eq("run_ready", 64'(bus.req_ready), 64'(0));
      end
    end
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        @(negedge clk);
        #1;
      end
      check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check_eq("rsp_id", 64'(bus.rsp_id), 64'(id));
      check_eq("rsp_z", 64'(bus.rsp_z), 64'(ez));
      check_eq("rsp_cycles", 64'(bus.rsp_cycles), 64'(run_len));
      check_eq("rsp_err", 64'(bus.rsp_err), 64'(err));
      check_eq("rsp_mismatch", 64'(bus.rsp_mismatch), 64'(em));
      check_eq("resp_core_en", 64'(bus.core_en), 64'(0));
      check_eq("resp_core_rst", 64'(bus.core_rst), 64'(1));
      check_eq("resp_ready", 64'(bus.req_ready), 64'(0));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check_eq("valid_drop", 64'(bus.rsp_valid), 64'(0));
    last_id = id;
  endtask

  initial begin
    int id, lat, stall;
    bit flt;
    logic [N-1:0] pat;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.req_valid = '1;
    #1;
    check_eq("rst_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("rst_id", 64'(bus.rsp_id), 64'(0));
    check_eq("rst_z", 64'(bus.rsp_z), 64'(0));
    check_eq("rst_cycles", 64'(bus.rsp_cycles), 64'(0));
    check_eq("rst_err", 64'(bus.rsp_err), 64'(0));
    check_eq("rst_mis", 64'(bus.rsp_mismatch), 64'(0));
    check_eq("rst_core_a", 64'({bus.core_a, bus.core_b, bus.core_c}), 64'(0));
    check_eq("rst_core_en", 64'(bus.core_en), 64'(0));
    check_eq("rst_core_rst", 64'(bus.core_rst), 64'(1));
    check_eq("rst_ready", 64'(bus.req_ready), 64'(0));
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Single job: requester 2, 15*15*15, ov on RUN cycle 10
    rand_ops();
    la[2] = 8'd15; lb[2] = 8'd15; lc[2] = 8'd15;
    issue(4'b0100, 4'b0000, 10, 1'b0, id);
    complete(id, 10, 0, 1'b0);

    // Round robin with everyone requesting continuously
    for (int j = 0; j < 5; j++) begin
      rand_ops();
      lat = $urandom_range(1, 12);
      issue(4'b1111, 4'b1111, lat, 1'b0, id);
      complete(id, lat, 0, 1'b0);
    end

    // Backpressure with requester 1 pending
    rand_ops();
    issue(4'b0001, 4'b0010, 4, 1'b0, id);
    complete(id, 4, 20, 1'b0);
    rand_ops();
    issue(4'b0010, 4'b0000, 3, 1'b0, id);
    complete(id, 3, 0, 1'b0);

    // Boundaries: timeout, ov on the timeout cycle, single-cycle run
    rand_ops();
    issue(4'b1111, 4'b0000, TO + 10, 1'b0, id);
    complete(id, TO + 10, 1, 1'b0);
    rand_ops();
    issue(4'b1111, 4'b0000, TO, 1'b0, id);
    complete(id, TO, 0, 1'b0);
    rand_ops();
    issue(4'b1111, 4'b0000, 1, 1'b0, id);
    complete(id, 1, 0, 1'b0);

    // Faulty core result: 200*3*7+1
    rand_ops();
    la[3] = 8'd200; lb[3] = 8'd3; lc[3] = 8'd7;
    issue(4'b1000, 4'b0000, 6, 1'b1, id);
    complete(id, 6, 0, 1'b1);

    // Reset on RUN cycle 5 drops the job
    rand_ops();
    issue(4'b0100, 4'b0000, 20, 1'b0, id);
    repeat (5) @(negedge clk);
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("midrst_core_rst", 64'(bus.core_rst), 64'(1));
    check_eq("midrst_core_en", 64'(bus.core_en), 64'(0));
    check_eq("midrst_core_a", 64'(bus.core_a), 64'(0));
    check_eq("midrst_ready", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      check_eq("postrst_valid", 64'(bus.rsp_valid), 64'(0));
    end
    last_id = N - 1;
    rand_ops();
    issue(4'b1111, 4'b0000, 3, 1'b0, id);
    complete(id, 3, 0, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      rand_ops();
      pat = N'($urandom_range(1, (1 << N) - 1));
      lat = $urandom_range(1, TO + 4);
      stall = $urandom_range(0, 3);
      flt = 1'($urandom_range(0, 1));
      issue(pat, N'($urandom), lat, flt, id);
      complete(id, lat, stall, flt);
    end
    bus.req_valid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
